alex_spi_master: RTL and testbench
==================================

Name: alex_spi_master

Overview:
- Parametrised SPI serialiser for Alex filter/antenna/attenuator control words; generalises the fixed two-word Tx/Rx link to NUM_WORDS words of WORD_W bits, each with its own load strobe.
- Adds a programmable SPI bit rate, a post-reset initial frame, a periodic refresh, a force request, a busy flag, and coalescing of changes that arrive mid-frame.
- Sits between the band/relay decode logic, which supplies the concatenated word bus, and the Alex board SPI pins.

Parameters:
- WORD_W, 16, bits per SPI word.
- NUM_WORDS, 2, number of words per frame; word i has load_strobe[i] (i=1 Tx, i=0 Rx in the default build).
- CLK_DIV, 8, system clocks per SPI half-bit; legal range >=1. Bit period is 2*CLK_DIV clocks.
- REFRESH_CYCLES, 0, idle clocks before an unchanged frame is resent; 0 disables refresh.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- alex_data  in  NUM_WORDS*WORD_W  word i occupies [i*WORD_W +: WORD_W].
- force_send  in  1  one-cycle pulse; requests a frame even when alex_data is unchanged.
- spi_data  out  1  serial data, MSB first.
- spi_clock  out  1  serial clock; idles low.
- load_strobe  out  NUM_WORDS  per-word latch strobe, active high.
- busy  out  1  high from frame start until return to IDLE.

Behaviour:
- Reset (asynchronous assert, synchronous deassert upstream):
  - spi_data=0, spi_clock=0, load_strobe=0, busy=0.
  - shadow register=0, pending=1, refresh counter=0, FSM=IDLE.
  - pending=1 at reset guarantees one initial frame after reset.
- Reset asserted mid-frame: all outputs go to reset values immediately. No partial strobe is ever issued; the frame restarts from word NUM_WORDS-1 after reset releases.
- Start condition in IDLE, evaluated each cycle: pending, OR alex_data!=shadow, OR force_send, OR (REFRESH_CYCLES>0 and refresh counter == REFRESH_CYCLES-1).
- Frame start, one clock after the start condition:
  - shadow <= alex_data; pending <= 0; refresh counter <= 0; busy <= 1.
  - FSM -> SHIFT with word index w=NUM_WORDS-1 and bit index b=WORD_W-1.
- Latency: the cycle after the start condition, spi_data already carries shadow bit MSB of word NUM_WORDS-1.
- SHIFT:
  - Each bit lasts 2*CLK_DIV clocks.
  - spi_data is held stable for the whole bit.
  - spi_clock is low for the first CLK_DIV clocks and high for the second CLK_DIV clocks (data is sampled on the rising edge at mid-bit).
  - After bit 0 the FSM goes to STROBE.
- STROBE: load_strobe[w]=1 for 2*CLK_DIV clocks; spi_clock=0; spi_data=0.
- GAP: 2*CLK_DIV clocks with all outputs low. Then:
  - if w>0: w<=w-1, b<=WORD_W-1, FSM -> SHIFT;
  - else FSM -> IDLE and busy<=0.
- Frame length: NUM_WORDS*(WORD_W+2)*2*CLK_DIV clocks, i.e. 576 for the defaults.
- Transmitted data always comes from shadow. alex_data changes during a frame never corrupt the frame in flight.
- Coalescing during a frame: if alex_data!=shadow, or force_send is seen, set pending=1. Exactly one follow-up frame is sent, carrying the newest alex_data; intermediate values are dropped.
- Refresh counter:
  - increments only in IDLE and saturates at REFRESH_CYCLES-1;
  - is cleared at every frame start;
  - has width clog2(REFRESH_CYCLES+1).
- Simultaneous events: change, force and refresh arriving in the same cycle start exactly one frame.
- Only one load_strobe bit is ever high at a time.
- Back-to-back frames: IDLE is occupied for exactly 1 clock between them (busy low for that clock).

Decomposition:
- Shared package alex_pkg:
  - FSM state enum {IDLE, SHIFT, STROBE, GAP};
  - default WORD_W/NUM_WORDS constants;
  - a clog2-based counter-width function.
- One natural sub-module, alex_spi_tick:
  - a divide-by-CLK_DIV counter producing a half-bit tick and phase (low/high half);
  - cleared on frame start and on reset.
- FSM, shadow register, change detect and refresh counter live in alex_spi_master.

Test Plan:
- Reset release with alex_data=0, CLK_DIV=1 -> one frame of 72 clocks: 32 zero bits, load_strobe[1] then load_strobe[0] each high 2 clocks; busy low afterwards.
- Idle frame, then alex_data=0xA5C3_0F81 (defaults) -> spi_data shows 1010010111000011 then 0000111110000001 MSB first, spi_clock high in the second half of each 16-clock bit, 576-clock frame; no further activity.
- Three alex_data changes during one frame (final value 0x1234_5678) -> exactly one follow-up frame, carrying 0x1234_5678, starting 1 clock after busy drops.
- Static data, REFRESH_CYCLES=100, CLK_DIV=1 -> a frame restarts every 100+72 clocks with identical content; force_send pulsed while idle -> frame starts the next clock.
- reset_n pulled low mid-way through word 1 -> spi_clock, spi_data, load_strobe and busy are 0 in the same cycle; after release a full frame is resent and no stray strobe appears.
- NUM_WORDS=3, WORD_W=8 -> strobes fire in order [2],[1],[0], each after 8 bits, and are never overlapping.

Source files
------------

// File: rtl/alex_pkg.sv
// Shared definitions for the Alex SPI serialiser.
//   alex_state_e   : frame sequencer states
//   ALEX_WORD_W    : default bits per SPI word
//   ALEX_NUM_WORDS : default words per frame
//   alex_cnt_w()   : width of a counter/index that must hold values 0..n-1
package alex_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        STROBE,
        GAP
    } alex_state_e;

    localparam int unsigned ALEX_WORD_W    = 16;
    localparam int unsigned ALEX_NUM_WORDS = 2;

    // Never returns zero so that degenerate parameter values still give a
    // legal one-bit vector.
    function automatic int unsigned alex_cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alex_spi_master_if.sv
// Alex board SPI pin bundle.
//   spi_data    : serial data, MSB first
//   spi_clock   : serial clock, idles low
//   load_strobe : per-word latch strobe, active high
// master drives the pins, slave observes them.
interface alex_spi_master_if
    import alex_pkg::*;
#(
    parameter int unsigned NUM_WORDS = ALEX_NUM_WORDS
) ();

    logic                 spi_data;
    logic                 spi_clock;
    logic [NUM_WORDS-1:0] load_strobe;

    modport master (
        output spi_data,
        output spi_clock,
        output load_strobe
    );

    modport slave (
        input spi_data,
        input spi_clock,
        input load_strobe
    );

endinterface

// File: rtl/alex_spi_tick.sv
// Half-bit timebase for the Alex SPI serialiser.
//   clock   : system clock
//   reset_n : asynchronous active-low reset
//   enable  : count while a frame is in progress
//   clear   : restart from the beginning of a low half-bit (frame start)
//   tick    : last clock of the current half-bit
//   phase   : 0 = low (first) half of the bit, 1 = high (second) half
module alex_spi_tick
    import alex_pkg::*;
#(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic tick,
    output logic phase
);

    localparam int unsigned      CNT_W   = alex_cnt_w(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             phase_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            phase_q <= 1'b0;
        end else if (clear) begin
            cnt     <= '0;
            phase_q <= 1'b0;
        end else if (enable) begin
            if (cnt == CNT_MAX) begin
                cnt     <= '0;
                phase_q <= ~phase_q;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        tick  = enable && (cnt == CNT_MAX);
        phase = phase_q;
    end

endmodule

// File: rtl/alex_spi_master.sv
// Alex filter/antenna/attenuator control-word serialiser.
// Sends NUM_WORDS words of WORD_W bits, highest word first, each followed by
// its own load strobe and an idle gap. A frame is sent after reset, on any
// change of alex_data, on force_send, and optionally as a periodic refresh.
// Changes seen mid-frame are coalesced into a single follow-up frame.
//   clock       : system clock
//   reset_n     : asynchronous active-low reset
//   alex_data   : word i at [i*WORD_W +: WORD_W]
//   force_send  : one-cycle request for a frame with unchanged data
//   spi         : SPI pins (spi_data, spi_clock, load_strobe)
//   busy        : high from frame start until return to IDLE
module alex_spi_master
    import alex_pkg::*;
#(
    parameter int unsigned WORD_W         = ALEX_WORD_W,
    parameter int unsigned NUM_WORDS      = ALEX_NUM_WORDS,
    parameter int unsigned CLK_DIV        = 8,
    parameter int unsigned REFRESH_CYCLES = 0
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_WORDS*WORD_W-1:0] alex_data,
    input  logic                        force_send,
    alex_spi_master_if.master           spi,
    output logic                        busy
);

    localparam int unsigned FRAME_W = NUM_WORDS * WORD_W;
    localparam int unsigned W_IDX_W = alex_cnt_w(NUM_WORDS);
    localparam int unsigned B_IDX_W = alex_cnt_w(WORD_W);
    localparam int unsigned REF_W   = alex_cnt_w(REFRESH_CYCLES + 1);

    localparam logic [W_IDX_W-1:0] LAST_WORD = W_IDX_W'(NUM_WORDS - 1);
    localparam logic [B_IDX_W-1:0] LAST_BIT  = B_IDX_W'(WORD_W - 1);
    localparam logic [REF_W-1:0]   REF_MAX   =
        REF_W'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);

    alex_state_e          state, state_n;
    logic [W_IDX_W-1:0]   w_idx, w_idx_n;
    logic [B_IDX_W-1:0]   b_idx, b_idx_n;
    logic [FRAME_W-1:0]   shadow;
    logic                 pending;
    logic [REF_W-1:0]     ref_cnt;

    logic                 half_tick;
    logic                 phase_high;
    logic                 bit_end;
    logic                 data_changed;
    logic                 refresh_hit;
    logic                 start;
    logic [WORD_W-1:0]    shadow_word;

    alex_spi_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (state != IDLE),
        .clear   (start),
        .tick    (half_tick),
        .phase   (phase_high)
    );

    always_comb begin
        data_changed = (alex_data != shadow);
        refresh_hit  = (REFRESH_CYCLES > 0) && (ref_cnt == REF_MAX);
        start        = (state == IDLE) &&
                       (pending || data_changed || force_send || refresh_hit);
        // every state lasts a whole bit period, so all transitions share
        // the end-of-high-half tick
        bit_end      = half_tick && phase_high;
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            w_idx <= '0;
            b_idx <= '0;
        end else begin
            state <= state_n;
            w_idx <= w_idx_n;
            b_idx <= b_idx_n;
        end
    end

    always_comb begin
        state_n = state;
        w_idx_n = w_idx;
        b_idx_n = b_idx;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SHIFT;
                    w_idx_n = LAST_WORD;
                    b_idx_n = LAST_BIT;
                end
            end
            SHIFT: begin
                if (bit_end) begin
                    if (b_idx == '0) begin
                        state_n = STROBE;
                    end else begin
                        b_idx_n = b_idx - B_IDX_W'(1);
                    end
                end
            end
            STROBE: begin
                if (bit_end) begin
                    state_n = GAP;
                end
            end
            GAP: begin
                if (bit_end) begin
                    if (w_idx != '0) begin
                        state_n = SHIFT;
                        w_idx_n = w_idx - W_IDX_W'(1);
                        b_idx_n = LAST_BIT;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // ------------------------------------- shadow, coalescing and refresh
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow  <= '0;
            pending <= 1'b1;
            ref_cnt <= '0;
        end else if (start) begin
            shadow  <= alex_data;
            pending <= 1'b0;
            ref_cnt <= '0;
        end else if (state != IDLE) begin
            if (data_changed || force_send) begin
                pending <= 1'b1;
            end
        end else if ((REFRESH_CYCLES > 0) && (ref_cnt != REF_MAX)) begin
            ref_cnt <= ref_cnt + REF_W'(1);
        end
    end

    // ---------------------------------------------------------- outputs
    // Outputs decode registered state only, so an asynchronous reset
    // forces all pins low in the same cycle without a partial strobe.
    always_comb begin
        shadow_word     = shadow[w_idx*WORD_W +: WORD_W];
        spi.spi_data    = (state == SHIFT) && shadow_word[b_idx];
        spi.spi_clock   = (state == SHIFT) && phase_high;
        spi.load_strobe = (state == STROBE) ? (NUM_WORDS'(1) << w_idx) : '0;
        busy            = (state != IDLE);
    end

endmodule

// File: tb/tb_alex_spi_master.sv
// Self-checking bench for alex_spi_master: four builds (fast 2x16, default
// 2x16 at CLK_DIV=8, fast with refresh, 3x8) driven from a vector table plus
// hand-written multi-cycle sequences.
module tb_alex_spi_master;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst_fast = 1'b0, rst_def = 1'b0, rst_ref = 1'b0, rst_w8 = 1'b0;
    logic [31:0] d_fast = '0, d_def = '0, d_ref = 32'hC0DE0042;
    logic [23:0] d_w8 = '0;
    logic        f_fast = 1'b0, f_def = 1'b0, f_ref = 1'b0, f_w8 = 1'b0;
    logic        b_fast, b_def, b_ref, b_w8;

    alex_spi_master_if #(.NUM_WORDS(2)) if_fast ();
    alex_spi_master_if #(.NUM_WORDS(2)) if_def ();
    alex_spi_master_if #(.NUM_WORDS(2)) if_ref ();
    alex_spi_master_if #(.NUM_WORDS(3)) if_w8 ();

    alex_spi_master #(.WORD_W(16), .NUM_WORDS(2), .CLK_DIV(1), .REFRESH_CYCLES(0)) u_fast (
        .clock(clock), .reset_n(rst_fast), .alex_data(d_fast), .force_send(f_fast),
        .spi(if_fast), .busy(b_fast));
    alex_spi_master #(.WORD_W(16), .NUM_WORDS(2), .CLK_DIV(8), .REFRESH_CYCLES(0)) u_def (
        .clock(clock), .reset_n(rst_def), .alex_data(d_def), .force_send(f_def),
        .spi(if_def), .busy(b_def));
    alex_spi_master #(.WORD_W(16), .NUM_WORDS(2), .CLK_DIV(1), .REFRESH_CYCLES(100)) u_ref (
        .clock(clock), .reset_n(rst_ref), .alex_data(d_ref), .force_send(f_ref),
        .spi(if_ref), .busy(b_ref));
    alex_spi_master #(.WORD_W(8), .NUM_WORDS(3), .CLK_DIV(2), .REFRESH_CYCLES(0)) u_w8 (
        .clock(clock), .reset_n(rst_w8), .alex_data(d_w8), .force_send(f_w8),
        .spi(if_w8), .busy(b_w8));

    // observed build: 0 fast, 1 default, 2 refresh, 3 three-word
    int         sel = 0;
    int         cfg_nw [4] = '{2, 2, 2, 3};
    int         cfg_ww [4] = '{16, 16, 16, 8};
    int         cfg_div[4] = '{1, 8, 1, 2};
    logic       m_data, m_clk, m_busy;
    logic [2:0] m_strobe;

    always_comb begin
        m_data = 1'b0; m_clk = 1'b0; m_busy = 1'b0; m_strobe = '0;
        case (sel)
            0: begin m_data = if_fast.spi_data; m_clk = if_fast.spi_clock;
                     m_strobe = {1'b0, if_fast.load_strobe}; m_busy = b_fast; end
            1: begin m_data = if_def.spi_data; m_clk = if_def.spi_clock;
                     m_strobe = {1'b0, if_def.load_strobe}; m_busy = b_def; end
            2: begin m_data = if_ref.spi_data; m_clk = if_ref.spi_clock;
                     m_strobe = {1'b0, if_ref.load_strobe}; m_busy = b_ref; end
            default: begin m_data = if_w8.spi_data; m_clk = if_w8.spi_clock;
                     m_strobe = if_w8.load_strobe; m_busy = b_w8; end
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int s, input logic [47:0] data, input bit frc);
        case (s)
            0: begin d_fast = data[31:0]; f_fast = frc; end
            1: begin d_def = data[31:0]; f_def = frc; end
            2: begin d_ref = data[31:0]; f_ref = frc; end
            default: begin d_w8 = data[23:0]; f_w8 = frc; end
        endcase
    endtask

    task automatic clear_force();
        f_fast = 1'b0; f_def = 1'b0; f_ref = 1'b0; f_w8 = 1'b0;
    endtask

    // Waits (bounded) for busy, then walks the whole frame one clock at a
    // time checking pin shape, and collects the transmitted bits. Returns at
    // the first clock after the last gap, where busy must already be low.
    task automatic capture(input int budget, output bit started, output int wait_n,
                           output logic [47:0] bits, output int len, output bit shape_ok);
        int   nw, ww, div;
        logic d0;
        nw = cfg_nw[sel]; ww = cfg_ww[sel]; div = cfg_div[sel];
        started = 1'b0; wait_n = 0; bits = '0; len = 0; shape_ok = 1'b1; d0 = 1'b0;
        while (!m_busy && wait_n < budget) begin
            @(negedge clock);
            wait_n++;
        end
        if (!m_busy) return;
        started = 1'b1;
        for (int w = nw - 1; w >= 0; w--) begin
            for (int b = ww - 1; b >= 0; b--) begin
                for (int c = 0; c < 2 * div; c++) begin
                    if (c == 0) begin
                        d0   = m_data;
                        bits = {bits[46:0], m_data};
                    end
                    if (m_data !== d0 || m_clk !== (c >= div) || m_strobe !== 3'b000 || m_busy !== 1'b1)
                        shape_ok = 1'b0;
                    len++;
                    @(negedge clock);
                end
            end
            for (int c = 0; c < 2 * div; c++) begin
                if (m_strobe !== 3'(1 << w) || m_clk !== 1'b0 || m_data !== 1'b0 || m_busy !== 1'b1)
                    shape_ok = 1'b0;
                len++;
                @(negedge clock);
            end
            for (int c = 0; c < 2 * div; c++) begin
                if (m_strobe !== 3'b000 || m_clk !== 1'b0 || m_data !== 1'b0 || m_busy !== 1'b1)
                    shape_ok = 1'b0;
                len++;
                @(negedge clock);
            end
        end
        if (m_busy !== 1'b0) shape_ok = 1'b0;
        while (m_busy && len < 4000) begin
            len++;
            @(negedge clock);
        end
    endtask

    task automatic idle_watch(input int n, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (m_busy || m_clk || m_data || m_strobe != 3'b000) seen = 1'b1;
            @(negedge clock);
        end
    endtask

    typedef struct {
        int          sel;
        logic [47:0] data;
        bit          force_req;
        bit          exp_frame;
        logic [47:0] exp_bits;
        int          exp_len;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          started, shape_ok, seen;
        int          wait_n, len;
        logic [47:0] bits;

        vecs[0] = '{0, 48'hDEADBEEF, 1'b0, 1'b1, 48'hDEADBEEF, 72};
        vecs[1] = '{0, 48'hDEADBEEF, 1'b0, 1'b0, 48'h0, 0};
        vecs[2] = '{0, 48'hDEADBEEF, 1'b1, 1'b1, 48'hDEADBEEF, 72};
        vecs[3] = '{0, 48'h00000001, 1'b1, 1'b1, 48'h00000001, 72};
        vecs[4] = '{0, 48'h00000001, 1'b0, 1'b0, 48'h0, 0};
        vecs[5] = '{0, 48'h80000000, 1'b0, 1'b1, 48'h80000000, 72};
        vecs[6] = '{1, 48'hA5C30F81, 1'b0, 1'b1, 48'hA5C30F81, 576};
        vecs[7] = '{1, 48'hA5C30F81, 1'b0, 1'b0, 48'h0, 0};
        vecs[8] = '{3, 48'h5AC381, 1'b0, 1'b1, 48'h5AC381, 120};
        vecs[9] = '{3, 48'h5AC381, 1'b1, 1'b1, 48'h5AC381, 120};

        repeat (3) @(negedge clock);
        sel = 0;
        check("reset_state", {m_busy, m_clk, m_data, m_strobe}, 6'b0);

        // initial frame after reset release, alex_data = 0
        rst_fast = 1'b1;
        capture(4, started, wait_n, bits, len, shape_ok);
        check("init_started", started, 1);
        check("init_bits", bits, 48'h0);
        check("init_shape", shape_ok, 1);
        check("init_len", len, 72);

        sel = 1; rst_def = 1'b1;
        capture(4, started, wait_n, bits, len, shape_ok);
        check("init_def_len", len, 576);
        sel = 3; rst_w8 = 1'b1;
        capture(4, started, wait_n, bits, len, shape_ok);
        check("init_w8_len", len, 120);

        // vector table
        foreach (vecs[i]) begin
            sel = vecs[i].sel;
            drive(vecs[i].sel, vecs[i].data, vecs[i].force_req);
            @(negedge clock);
            clear_force();
            if (vecs[i].exp_frame) begin
                check($sformatf("v%0d_start", i), m_busy, 1);
                capture(2, started, wait_n, bits, len, shape_ok);
                check($sformatf("v%0d_bits", i), bits, vecs[i].exp_bits);
                check($sformatf("v%0d_shape", i), shape_ok, 1);
                check($sformatf("v%0d_len", i), len, vecs[i].exp_len);
            end else begin
                check($sformatf("v%0d_nostart", i), m_busy, 0);
                idle_watch(80, seen);
                check($sformatf("v%0d_idle", i), seen, 0);
            end
        end

        // three changes during one frame coalesce into one follow-up frame
        sel = 0;
        d_fast = 32'h11112222;
        fork
            capture(4, started, wait_n, bits, len, shape_ok);
            begin
                repeat (5) @(negedge clock);  d_fast = 32'hAAAA5555;
                repeat (15) @(negedge clock); d_fast = 32'h0F0F0F0F;
                repeat (20) @(negedge clock); d_fast = 32'h12345678;
            end
        join
        check("coal_first_bits", bits, 48'h11112222);
        check("coal_first_shape", shape_ok, 1);
        capture(4, started, wait_n, bits, len, shape_ok);
        check("coal_followup_wait", wait_n, 1);
        check("coal_followup_bits", bits, 48'h12345678);
        check("coal_followup_shape", shape_ok, 1);
        idle_watch(100, seen);
        check("coal_single", seen, 0);

        // reset during word 1
        d_fast = 32'hFFFF0000;
        @(negedge clock);
        check("rst_mid_start", m_busy, 1);
        repeat (5) @(negedge clock);
        check("rst_mid_active", {m_clk, m_data}, 2'b11);
        rst_fast = 1'b0;
        #1;
        check("rst_mid_pins", {m_busy, m_clk, m_data, m_strobe}, 6'b0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (m_busy || m_strobe != 3'b000) seen = 1'b1;
        end
        check("rst_mid_held", seen, 0);
        rst_fast = 1'b1;
        capture(4, started, wait_n, bits, len, shape_ok);
        check("rst_resend_started", started, 1);
        check("rst_resend_bits", bits, 48'hFFFF0000);
        check("rst_resend_shape", shape_ok, 1);
        check("rst_resend_len", len, 72);

        // periodic refresh with static data, then force while idle
        sel = 2; rst_ref = 1'b1;
        capture(4, started, wait_n, bits, len, shape_ok);
        check("ref_init_bits", bits, 48'hC0DE0042);
        for (int k = 0; k < 2; k++) begin
            capture(200, started, wait_n, bits, len, shape_ok);
            check($sformatf("ref%0d_wait", k), wait_n, 100);
            check($sformatf("ref%0d_bits", k), bits, 48'hC0DE0042);
            check($sformatf("ref%0d_shape", k), shape_ok, 1);
        end
        repeat (10) @(negedge clock);
        f_ref = 1'b1;
        @(negedge clock);
        f_ref = 1'b0;
        check("force_latency", m_busy, 1);
        capture(2, started, wait_n, bits, len, shape_ok);
        check("force_bits", bits, 48'hC0DE0042);
        check("force_len", len, 72);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
